// File: rtl/hazard_ctrl.sv
// Hazard controller for the five-stage MIPS core. It drives decode and execute forwarding,
// stall and flush, sequences the shared mult/div unit, and counts stalled cycles.
module hazard_ctrl #(
    parameter int MUL_CYCLES = 4,
    parameter int DIV_CYCLES = 32
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic [4:0]  rs_d_i,
    input  logic [4:0]  rt_d_i,
    input  logic [1:0]  branch_d_i,
    input  logic        jr_d_i,
    input  logic        md_start_d_i,
    input  logic        md_is_div_d_i,
    input  logic        md_read_d_i,
    input  logic [4:0]  rs_e_i,
    input  logic [4:0]  rt_e_i,
    input  logic [4:0]  write_reg_e_i,
    input  logic        reg_write_e_i,
    input  logic        mem_to_reg_e_i,
    input  logic [4:0]  write_reg_m_i,
    input  logic        reg_write_m_i,
    input  logic        mem_to_reg_m_i,
    input  logic [4:0]  write_reg_w_i,
    input  logic        reg_write_w_i,
    output logic        stall_f_o,
    output logic        stall_d_o,
    output logic        flush_e_o,
    output logic        forward_a_d_o,
    output logic        forward_b_d_o,
    output logic [1:0]  forward_a_e_o,
    output logic [1:0]  forward_b_e_o,
    output logic        md_start_o,
    output logic        md_busy_o,
    output logic        md_done_o,
    output logic [31:0] stall_count_o
);
    localparam int CW = $clog2(DIV_CYCLES + 1);

    typedef enum logic {IDLE, BUSY} state_t;

    state_t        state;
    logic [CW-1:0] cnt;
    logic          lw_stall, br_stall, md_stall, stall;
    logic          rs_rd_d, rt_rd_d;

    function automatic logic match(input logic [4:0] x, input logic [4:0] y);
        return (x == y) && (x != 5'd0);
    endfunction

    always_comb begin
        forward_a_e_o = 2'b00;
        if (reg_write_m_i && match(write_reg_m_i, rs_e_i))      forward_a_e_o = 2'b10;
        else if (reg_write_w_i && match(write_reg_w_i, rs_e_i)) forward_a_e_o = 2'b01;
        forward_b_e_o = 2'b00;
        if (reg_write_m_i && match(write_reg_m_i, rt_e_i))      forward_b_e_o = 2'b10;
        else if (reg_write_w_i && match(write_reg_w_i, rt_e_i)) forward_b_e_o = 2'b01;
    end

    assign forward_a_d_o = reg_write_m_i && match(write_reg_m_i, rs_d_i);
    assign forward_b_d_o = reg_write_m_i && match(write_reg_m_i, rt_d_i);

    assign lw_stall = mem_to_reg_e_i &&
                      (match(write_reg_e_i, rs_d_i) || match(write_reg_e_i, rt_d_i));

    // jr only reads rs in decode; branches read both operands for the early compare
    assign rs_rd_d  = (branch_d_i != 2'b00) || jr_d_i;
    assign rt_rd_d  = (branch_d_i != 2'b00);
    assign br_stall =
        (rs_rd_d && ((reg_write_e_i  && match(write_reg_e_i, rs_d_i)) ||
                     (mem_to_reg_m_i && match(write_reg_m_i, rs_d_i)))) ||
        (rt_rd_d && ((reg_write_e_i  && match(write_reg_e_i, rt_d_i)) ||
                     (mem_to_reg_m_i && match(write_reg_m_i, rt_d_i))));

    assign md_busy_o  = (state == BUSY);
    assign md_stall   = md_busy_o && (md_start_d_i || md_read_d_i);
    assign stall      = lw_stall || br_stall || md_stall;
    assign stall_f_o  = stall;
    assign stall_d_o  = stall;
    assign flush_e_o  = stall;
    assign md_start_o = (state == IDLE) && md_start_d_i && !lw_stall && !br_stall;

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state         <= IDLE;
            cnt           <= '0;
            md_done_o     <= 1'b0;
            stall_count_o <= 32'd0;
        end else begin
            md_done_o <= 1'b0;
            if (stall) stall_count_o <= stall_count_o + 32'd1;
            case (state)
                IDLE: if (md_start_o) begin
                    state <= BUSY;
                    cnt   <= md_is_div_d_i ? CW'(DIV_CYCLES - 1) : CW'(MUL_CYCLES - 1);
                end
                BUSY: if (cnt != '0) begin
                    cnt <= cnt - 1'b1;
                end else begin
                    state     <= IDLE;
                    md_done_o <= 1'b1;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
